// File: rtl/spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spm_seq_ctrl
//
// Sequencer wrapped around a serial-parallel multiplier (spm). Accepts an
// operand pair (x, y) on a valid/ready port, pulses the spm reset, presents x
// in parallel, and streams y LSB-first (followed by SIZE extension bits and
// P_LAT flush zeros). The serial product bits that return on spm_p are
// shifted into a 2*SIZE-bit word, which is then offered on a valid/ready port.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   high only in IDLE while rst is low
//   in_x       parallel multiplicand (two's complement)
//   in_y       multiplier, serialised to the spm
//   spm_rst    reset to the spm instance (high in CLEAR and while rst is high)
//   spm_x      parallel operand to the spm, held through the run
//   spm_y      serial operand bit to the spm (registered)
//   spm_p      serial product bit from the spm, P_LAT cycles after spm_y
//   out_valid  product valid, held until out_ready
//   out_ready  consumer accepts the product
//   out_p      product, modulo 2^(2*SIZE)
//
// Parameters
//   SIZE       operand width; must match the spm instance
//   SIGNED_Y   1: y is sign-extended beyond SIZE bits, 0: zero-extended
//   P_LAT      cycles from a bit on spm_y to its product bit on spm_p
// -----------------------------------------------------------------------------
module spm_seq_ctrl #(
  parameter int SIZE     = 32,
  parameter int SIGNED_Y = 1,
  parameter int P_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_x,
  input  logic [SIZE-1:0]   in_y,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_p
);

  // A run feeds 2*SIZE operand bits plus P_LAT flush cycles so the last
  // product bit has time to come back out of the spm.
  localparam int RUN_LEN = 2*SIZE + P_LAT;
  localparam int CNT_W   = $clog2(RUN_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_PLAT  = CNT_W'(P_LAT);
  localparam logic [CNT_W-1:0] CNT_SIZE  = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] CNT_2SIZE = CNT_W'(2*SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SIZE-1:0]     x_q;
  logic [SIZE-1:0]     y_q;
  logic                spm_y_q;
  logic                out_valid_q;
  logic [2*SIZE-1:0]   out_p_q;

  logic [CNT_W-1:0]    cnt_d;
  logic [SIZE-1:0]     y_shift;
  logic                y_ext;
  logic                spm_y_d;

  // spm_y is registered, so the bit for RUN cycle cnt+1 is chosen during
  // RUN cycle cnt: y bits first, then the extension bit, then zeros.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    cnt_d   = cnt_q + CNT_W'(1);
    y_shift = y_q >> cnt_d;
    y_ext   = (SIGNED_Y != 0) ? y_q[SIZE-1] : 1'b0;
    spm_y_d = 1'b0;
    if (cnt_d < CNT_SIZE) begin
      spm_y_d = y_shift[0];
    end else if (cnt_d < CNT_2SIZE) begin
      spm_y_d = y_ext;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      spm_y_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_q     <= in_x;
            y_q     <= in_y;
            state_q <= CLEAR;
          end
        end

        CLEAR: begin
          cnt_q   <= '0;
          out_p_q <= '0;
          spm_y_q <= y_q[0];
          state_q <= RUN;
        end

        RUN: begin
          // The first P_LAT cycles of spm_p still belong to the cleared spm.
          if (cnt_q >= CNT_PLAT) begin
            out_p_q <= {spm_p, out_p_q[2*SIZE-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            spm_y_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q   <= cnt_d;
            spm_y_q <= spm_y_d;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst keeps an offer from looking accepted during a reset cycle.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign spm_rst   = rst || (state_q == CLEAR);
  assign spm_x     = x_q;
  assign spm_y     = spm_y_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spm_seq_ctrl
//
// Two sequencers share one stimulus stream: one with a signed multiplier, one
// with an unsigned multiplier. Each drives its own behavioural spm, modelled
// as an accumulator of shifted partial products with a one-cycle output
// register. Expected products come from plain integer multiplication.
// All stimulus changes and output samples happen on the falling edge.
// -----------------------------------------------------------------------------
module tb_spm_seq_ctrl;

  localparam int SIZE   = 8;
  localparam int P_LAT  = 1;
  localparam int PW     = 2*SIZE;
  localparam int LAT    = 2*SIZE + P_LAT + 2;
  localparam int PERIOD = 2*SIZE + P_LAT + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            out_ready;
  logic [SIZE-1:0] in_x;
  logic [SIZE-1:0] in_y;

  logic            s_in_ready, s_spm_rst, s_spm_y, s_out_valid;
  logic            s_spm_p = 1'b0;
  logic [SIZE-1:0] s_spm_x;
  logic [PW-1:0]   s_out_p;

  logic            u_in_ready, u_spm_rst, u_spm_y, u_out_valid;
  logic            u_spm_p = 1'b0;
  logic [SIZE-1:0] u_spm_x;
  logic [PW-1:0]   u_out_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  spm_seq_ctrl #(.SIZE(SIZE), .SIGNED_Y(1), .P_LAT(P_LAT)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_x(in_x), .in_y(in_y),
    .spm_rst(s_spm_rst), .spm_x(s_spm_x), .spm_y(s_spm_y), .spm_p(s_spm_p),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_p(s_out_p)
  );

  spm_seq_ctrl #(.SIZE(SIZE), .SIGNED_Y(0), .P_LAT(P_LAT)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_x(in_x), .in_y(in_y),
    .spm_rst(u_spm_rst), .spm_x(u_spm_x), .spm_y(u_spm_y), .spm_p(u_spm_p),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_p(u_out_p)
  );

  // ---------------------------------------------------------------------------
  // Behavioural spm: the k-th y bit after reset adds y_k * x * 2^k; product
  // bit k is final once bit k has been added and appears one cycle later.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] s_acc, u_acc;
  int            s_k, u_k;

  function automatic logic [PW-1:0] spm_acc_next(logic [PW-1:0] acc, logic [SIZE-1:0] x,
                                                 logic y, int k);
    longint xs;
    xs = $signed(x);
    if (y && k < PW) return acc + PW'(xs << k);
    return acc;
  endfunction

  function automatic logic spm_bit(logic [PW-1:0] acc, int k);
    if (k < PW) return acc[k];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (s_spm_rst) begin
      s_acc <= '0; s_k <= 0; s_spm_p <= 1'b0;
    end else begin
      s_acc   <= spm_acc_next(s_acc, s_spm_x, s_spm_y, s_k);
      s_spm_p <= spm_bit(spm_acc_next(s_acc, s_spm_x, s_spm_y, s_k), s_k);
      if (s_k < PW) s_k <= s_k + 1;
    end
  end

  always @(posedge clk) begin
    if (u_spm_rst) begin
      u_acc <= '0; u_k <= 0; u_spm_p <= 1'b0;
    end else begin
      u_acc   <= spm_acc_next(u_acc, u_spm_x, u_spm_y, u_k);
      u_spm_p <= spm_bit(spm_acc_next(u_acc, u_spm_x, u_spm_y, u_k), u_k);
      if (u_k < PW) u_k <= u_k + 1;
    end
  end

  // Reference product: low PW bits of signed(x) * ext(y).
  function automatic logic [PW-1:0] ref_prod(logic [SIZE-1:0] x, logic [SIZE-1:0] y, bit sy);
    longint xs, ys, p;
    xs = $signed(x);
    if (sy) begin
      ys = $signed(y);
    end else begin
      ys = 0;
      ys[SIZE-1:0] = y;
    end
    p = xs * ys;
    return p[PW-1:0];
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Waits (bounded) until the signed instance offers in_ready with in_valid up.
  task automatic wait_accept(output int acc_cyc, output bit ok, input string name);
    int n = 0;
    while (s_in_ready !== 1'b1 && n < 8*PERIOD) begin
      step();
      n++;
    end
    ok      = (s_in_ready === 1'b1);
    acc_cyc = cyc;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: in_ready still %b after %0d cycles, required 1", name, s_in_ready, n);
    end
    checks++;
    if (u_in_ready !== s_in_ready) begin
      failures++;
      $display("FAIL %s: unsigned in_ready=%b, required %b", name, u_in_ready, s_in_ready);
    end
  endtask

  // Called on the cycle after an accept; returns on the first out_valid cycle.
  task automatic wait_product(input int acc_cyc, input logic [PW-1:0] exp_s,
                              input logic [PW-1:0] exp_u, input logic [SIZE-1:0] x,
                              input string name);
    int n = 0;
    while (s_out_valid !== 1'b1 && n < 4*PERIOD) begin
      checks++;
      if (s_spm_x !== x || s_spm_rst !== (cyc == acc_cyc + 1)) begin
        failures++;
        $display("FAIL %s: cycle %0d spm_x=%h spm_rst=%b, required spm_x=%h spm_rst=%b",
                 name, cyc - acc_cyc, s_spm_x, s_spm_rst, x, (cyc == acc_cyc + 1));
      end
      step();
      n++;
    end
    checks++;
    if (s_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s: out_valid never rose within %0d cycles", name, n);
      return;
    end
    checks++;
    if (cyc - acc_cyc != LAT) begin
      failures++;
      $display("FAIL %s: latency %0d cycles, required %0d", name, cyc - acc_cyc, LAT);
    end
    checks++;
    if (s_out_p !== exp_s) begin
      failures++;
      $display("FAIL %s: signed out_p=%h, required %h", name, s_out_p, exp_s);
    end
    checks++;
    if (u_out_valid !== 1'b1 || u_out_p !== exp_u) begin
      failures++;
      $display("FAIL %s: unsigned out_valid=%b out_p=%h, required 1 %h",
               name, u_out_valid, u_out_p, exp_u);
    end
  endtask

  // One complete operation with no backpressure.
  task automatic run_op(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                        input logic [PW-1:0] exp_s, input logic [PW-1:0] exp_u,
                        input string name);
    int acc_cyc;
    bit ok;
    in_x = x; in_y = y; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(acc_cyc, ok, name);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    in_x = SIZE'($urandom);
    in_y = SIZE'($urandom);
    wait_product(acc_cyc, exp_s, exp_u, x, name);
    step();
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: after handshake out_valid=%b in_ready=%b, required 0 1",
               name, s_out_valid, s_in_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    repeat (3) step();
    checks++;
    if (s_in_ready !== 1'b0 || u_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: %b/%b, required 0/0", s_in_ready, u_in_ready);
    end
    checks++;
    if (s_spm_rst !== 1'b1 || s_spm_x !== '0 || s_spm_y !== 1'b0) begin
      failures++;
      $display("FAIL reset_spm: rst=%b x=%h y=%b, required 1 00 0", s_spm_rst, s_spm_x, s_spm_y);
    end
    checks++;
    if (s_out_valid !== 1'b0 || s_out_p !== '0) begin
      failures++;
      $display("FAIL reset_out: valid=%b p=%h, required 0 0000", s_out_valid, s_out_p);
    end
    rst = 1'b0;
    step();
    checks++;
    if (s_in_ready !== 1'b1 || s_spm_rst !== 1'b0 || u_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: in_ready=%b spm_rst=%b, required 1 0", s_in_ready, s_spm_rst);
    end
  endtask

  task automatic test_basic();
    run_op(8'd50, 8'hCE, 16'hF63C, 16'h283C, "mul_50_by_0xCE");
  endtask

  task automatic test_corners();
    run_op(8'h80, 8'h80, 16'h4000, ref_prod(8'h80, 8'h80, 1'b0), "corner_min_min");
    run_op(8'h7F, 8'hFF, 16'hFF81, ref_prod(8'h7F, 8'hFF, 1'b0), "corner_max_m1");
    run_op(8'h00, 8'hA5, 16'h0000, 16'h0000, "corner_zero_x");
  endtask

  task automatic test_backpressure();
    logic [SIZE-1:0] x1, y1, x2, y2;
    logic [PW-1:0]   hold_p;
    int              acc_cyc;
    bit              ok;
    x1 = SIZE'($urandom); y1 = SIZE'($urandom);
    x2 = SIZE'($urandom); y2 = SIZE'($urandom);
    in_x = x1; in_y = y1; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept(acc_cyc, ok, "bp_accept1");
    if (!ok) begin
      in_valid = 1'b0; out_ready = 1'b1;
      return;
    end
    step();
    in_valid = 1'b0;
    wait_product(acc_cyc, ref_prod(x1, y1, 1'b1), ref_prod(x1, y1, 1'b0), x1, "bp_op1");
    if (s_out_valid !== 1'b1) begin
      out_ready = 1'b1;
      return;
    end
    hold_p = s_out_p;
    // Offer the next pair while the product is stalled; it must wait.
    in_x = x2; in_y = y2; in_valid = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      checks++;
      if (s_out_valid !== 1'b1 || s_out_p !== hold_p || s_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: DONE cycle %0d valid=%b p=%h in_ready=%b, required 1 %h 0",
                 i, s_out_valid, s_out_p, s_in_ready, hold_p);
      end
      if (i < 11) step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", s_out_valid, s_in_ready);
    end
    acc_cyc = cyc;
    step();
    in_valid = 1'b0;
    wait_product(acc_cyc, ref_prod(x2, y2, 1'b1), ref_prod(x2, y2, 1'b0), x2, "bp_op2");
    step();
    checks++;
    if (s_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_op2_done: out_valid=%b, required 0", s_out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int acc_cyc;
    bit ok;
    bit rose = 1'b0;
    in_x = 8'h5A; in_y = 8'h33; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(acc_cyc, ok, "abort_accept");
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    // Accept cycle + 2 is RUN count 0, so +7 is RUN count 5.
    while (cyc < acc_cyc + 7) step();
    rst = 1'b1;
    step();
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b0 || s_spm_rst !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_reset: out_valid=%b in_ready=%b spm_rst=%b, required 0 0 1",
               s_out_valid, s_in_ready, s_spm_rst);
    end
    rst = 1'b0;
    step();
    checks++;
    if (s_in_ready !== 1'b1 || s_spm_rst !== 1'b0 || u_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_release: in_ready=%b spm_rst=%b, required 1 0", s_in_ready, s_spm_rst);
    end
    repeat (PERIOD + 10) begin
      if (s_out_valid !== 1'b0 || u_out_valid !== 1'b0) rose = 1'b1;
      step();
    end
    checks++;
    if (rose) begin
      failures++;
      $display("FAIL abort_no_valid: out_valid rose after abort, required to stay 0");
    end
    run_op(8'd3, 8'hFE, 16'hFFFA, 16'h02FA, "after_abort_3_by_m2");
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] x, y;
    int              acc_cyc;
    int              prev_cyc = 0;
    bit              ok;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = SIZE'($urandom); y = SIZE'($urandom);
      in_x = x; in_y = y;
      wait_accept(acc_cyc, ok, "b2b_accept");
      if (!ok) break;
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev_cyc != PERIOD) begin
          failures++;
          $display("FAIL b2b_spacing: accept %0d spaced %0d cycles, required %0d",
                   i, acc_cyc - prev_cyc, PERIOD);
        end
      end
      prev_cyc = acc_cyc;
      step();
      wait_product(acc_cyc, ref_prod(x, y, 1'b1), ref_prod(x, y, 1'b0), x, "b2b_product");
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [SIZE-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      x = SIZE'($urandom); y = SIZE'($urandom);
      run_op(x, y, ref_prod(x, y, 1'b1), ref_prod(x, y, 1'b0), "random_op");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
